maxpool2d: RTL and testbench
============================

# maxpool2d

Streaming 2x2, stride-2 signed max-pooling stage that sits directly downstream of the 2-D convolution block. It consumes the convolution's raster-ordered valid-window output stream and emits one pooled value per non-overlapping 2x2 tile. This halves each spatial dimension before the next stage. Partial row maxima are held in an internal half-line buffer, so the block needs no frame storage and accepts one pixel per cycle.

## Interface
- linewidth_px_p, 158: pixels per input line (conv output width); must be >= 2
- linecount_px_p, 118: lines per input frame; must be >= 2
- width_p, 32: signed data width, in and out
- clk_i  input  1  clock
- reset_i  input  1  synchronous, active-high reset
- valid_i  input  1  upstream data valid
- ready_o  output  1  block can accept data_i this cycle
- data_i  input  width_p  signed input pixel, raster order
- valid_o  output  1  data_o holds a pooled result
- ready_i  input  1  downstream accepts data_o
- data_o  output  width_p  signed pooled result

## Operation
- Accept: enable = valid_i & ready_o. All state advances only on enable.
- Position counters x (0..linewidth_px_p-1) and y (0..linecount_px_p-1):
  - x wraps to 0 at the end of each line and y increments.
  - y wraps to 0 after the last line; frames are back-to-back with no gap required.
- Even x: store data_i in the column-pair register.
- Odd x: pair max m = signed max(column-pair register, data_i).
  - Even y: write m to half-line buffer entry x>>1.
  - Odd y: result = signed max(buffer[x>>1], m); this is a produce event.
- Buffer has linewidth_px_p/2 entries (floor). Buffer read is combinational, so the result resolves in the accept cycle.
- Odd linewidth_px_p: the last column (x = W-1) is accepted and discarded; it is never written and never compared.
- Odd linecount_px_p: the last row is written to the buffer but never consumed. The next frame's row 0 overwrites it.
- Output size per frame: floor(W/2) x floor(H/2) results.
- Ties: any equal value is correct, since the values are identical.
- All comparisons are signed two's complement at full width_p; no truncation.

## Timing
- Output stage is a single elastic register:
  - ready_o = ~valid_o | ready_i.
  - When ready_o is high: valid_o <= produce and data_o <= result (data_o updates only on produce).
- Latency: valid_o rises the cycle after the accept of the bottom-right pixel of a tile.
- Throughput: 1 pixel/cycle with ready_i held high. Output rate is at most 1 per 4 accepted pixels.
- Backpressure: while valid_o=1 and ready_i=0, ready_o=0. No input is accepted, and data_o/valid_o hold stable.
- Simultaneous consume and produce (valid_o=1, ready_i=1, new produce): valid_o stays 1 and data_o is replaced with no bubble.
- valid_i low: no state change. Counters do not advance on unaccepted cycles.
- Reset values: valid_o=0, data_o=0, x=0, y=0, column-pair register=0. Buffer contents need no reset; they are always written before being read.
- Reset mid-frame: reset for one cycle clears everything above. The next accepted pixel is treated as (0,0), and any in-flight tile is dropped.

## Configuration
- MAXPOOL2D_RELU_EN defined: the final result is clamped, so a negative result becomes 0 before it is registered into data_o. The clamp is applied once, after the 4-way max.
- Not defined: data_o carries the signed max unchanged, and negative outputs pass through.

## Test plan
- 4x4 frame, values 0..15 in raster order, ready_i=1:
  - Outputs in order 5, 7, 13, 15.
  - Each valid_o pulse arrives 1 cycle after accepting pixels 5, 7, 13, 15 respectively.
- 4x4 frame of all-negative values -16..-1 (raster), macro undefined: outputs -11, -9, -3, -1. Same stimulus with MAXPOOL2D_RELU_EN: outputs 0, 0, 0, 0.
- 5x5 frame (W=H=5), values 0..24:
  - Outputs 6, 8, 16, 18 only.
  - Column 4 and row 4 produce no output.
  - A second back-to-back frame yields the same four values.
- Backpressure: 4x4 ramp with ready_i=0 for 5 cycles after the first valid_o:
  - data_o holds 5 and ready_o=0 throughout.
  - No input is lost; after release, the remaining outputs 7, 13, 15 are correct.
- Random valid_i and ready_i toggling over 3 consecutive 158x118 frames of random signed 32-bit data: output stream matches a software 2x2 max-pool model exactly (count 79x59 per frame).
- Reset asserted after 6 pixels of a 4x4 frame, then a fresh 4x4 ramp 0..15:
  - valid_o=0 and data_o=0 the cycle after reset.
  - Outputs are 5, 7, 13, 15 with no stale values.

Source files
------------

// File: rtl/maxpool2d.sv
// Streaming 2x2 stride-2 signed max-pool over a raster pixel stream, using a half-line buffer.
// Optional feature: define MAXPOOL2D_RELU_EN to clamp negative pooled results to zero.
module maxpool2d #(
    parameter int linewidth_px_p = 158,
    parameter int linecount_px_p = 118,
    parameter int width_p        = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic signed [width_p-1:0] data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic signed [width_p-1:0] data_o
);
    localparam int half_lp   = linewidth_px_p / 2;
    localparam int x_w_lp    = $clog2(linewidth_px_p);
    localparam int y_w_lp    = $clog2(linecount_px_p);
    localparam int addr_w_lp = (half_lp > 1) ? $clog2(half_lp) : 1;
    localparam logic [x_w_lp-1:0] x_last_lp = x_w_lp'(linewidth_px_p - 1);
    localparam logic [y_w_lp-1:0] y_last_lp = y_w_lp'(linecount_px_p - 1);

    logic [x_w_lp-1:0]         x_r;
    logic [y_w_lp-1:0]         y_r;
    logic signed [width_p-1:0] col_r;
    logic signed [width_p-1:0] line_mem [half_lp];

    logic                      enable;
    logic                      odd_col;
    logic                      odd_row;
    logic                      produce;
    logic [addr_w_lp-1:0]      addr;
    logic signed [width_p-1:0] above;
    logic signed [width_p-1:0] pair_max;
    logic signed [width_p-1:0] tile_max;
    logic signed [width_p-1:0] result;

    assign ready_o = ~valid_o | ready_i;
    assign enable  = valid_i & ready_o;
    assign odd_col = x_r[0];
    assign odd_row = y_r[0];
    assign addr    = addr_w_lp'(x_r >> 1);

    // An odd-width line ends on an even column, so its last pixel never reaches the pair logic.
    always_comb begin
        above    = line_mem[addr];
        pair_max = (data_i > col_r) ? data_i : col_r;
        tile_max = (above > pair_max) ? above : pair_max;
        result   = tile_max;
`ifdef MAXPOOL2D_RELU_EN
        if (tile_max < 0) begin
            result = '0;
        end
`endif
        produce  = enable & odd_col & odd_row;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_r     <= '0;
            y_r     <= '0;
            col_r   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (enable) begin
                if (x_r == x_last_lp) begin
                    x_r <= '0;
                    y_r <= (y_r == y_last_lp) ? '0 : y_r + 1'b1;
                end else begin
                    x_r <= x_r + 1'b1;
                end
                if (!odd_col) begin
                    col_r <= data_i;
                end
            end
            if (ready_o) begin
                valid_o <= produce;
                if (produce) begin
                    data_o <= result;
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; every entry is written on an even row before it is read.
    always_ff @(posedge clk_i) begin
        if (enable && odd_col && !odd_row) begin
            line_mem[addr] <= pair_max;
        end
    end
endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: three instances (4x4, 5x5, 158x118) and a scoreboard queue.
module tb_maxpool2d;
    localparam int big_w = 158;
    localparam int big_h = 118;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset = 1'b1;
    logic                valid = 1'b0;
    logic                rdy   = 1'b1;
    logic signed [31:0]  din   = '0;
    int                  sel   = 0;
    bit                  rand_mode = 1'b0;

    logic                vi   [3];
    logic                ro   [3];
    logic                vo   [3];
    logic signed [31:0]  dout [3];
    logic                ro_a;
    logic                vo_a;
    logic signed [31:0]  do_a;

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [31:0] exp_q [$];
    logic signed [31:0] frame [big_w*big_h];

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            vi[s] = valid && (sel == s);
        end
        ro_a = ro[sel];
        vo_a = vo[sel];
        do_a = dout[sel];
    end

    maxpool2d #(.linewidth_px_p(4), .linecount_px_p(4), .width_p(32)) u_d4 (
        .clk_i(clk), .reset_i(reset), .valid_i(vi[0]), .ready_o(ro[0]), .data_i(din),
        .valid_o(vo[0]), .ready_i(rdy), .data_o(dout[0]));
    maxpool2d #(.linewidth_px_p(5), .linecount_px_p(5), .width_p(32)) u_d5 (
        .clk_i(clk), .reset_i(reset), .valid_i(vi[1]), .ready_o(ro[1]), .data_i(din),
        .valid_o(vo[1]), .ready_i(rdy), .data_o(dout[1]));
    maxpool2d #(.linewidth_px_p(big_w), .linecount_px_p(big_h), .width_p(32)) u_big (
        .clk_i(clk), .reset_i(reset), .valid_i(vi[2]), .ready_o(ro[2]), .data_i(din),
        .valid_o(vo[2]), .ready_i(rdy), .data_o(dout[2]));

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: a transfer completes at the next posedge whenever valid_o & ready_i here.
    always @(negedge clk) begin
        if (vo_a && rdy) begin
            check("out_avail", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("out_data", do_a, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1 rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Drives one pixel; called and returns at posedge+1 of the accepting cycle.
    task automatic send(input logic signed [31:0] d);
        bit acc = 1'b0;
        if (rand_mode) begin
            while ($urandom_range(0, 7) == 0) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        valid = 1'b1;
        din   = d;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = ro_a;
            @(posedge clk); #1;
        end
        if (!acc) check("accept_timeout", acc, 1);
        valid = 1'b0;
    endtask

    task automatic push_model(input int w, input int h);
        logic signed [31:0] m;
        int b;
        for (int ty = 0; ty < h / 2; ty++) begin
            for (int tx = 0; tx < w / 2; tx++) begin
                b = 2 * ty * w + 2 * tx;
                m = frame[b];
                if (frame[b+1] > m)   m = frame[b+1];
                if (frame[b+w] > m)   m = frame[b+w];
                if (frame[b+w+1] > m) m = frame[b+w+1];
`ifdef MAXPOOL2D_RELU_EN
                if (m < 0) m = 0;
`endif
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_valid", vo_a, 0);
        check("rst_data", do_a, 0);
        check("rst_ready", ro_a, 1);

        // 4x4 ramp: exact output cycles
        exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(13); exp_q.push_back(15);
        for (int i = 0; i < 16; i++) begin
            send(i);
            check("lat_valid", vo_a, (i == 5 || i == 7 || i == 13 || i == 15));
            if (vo_a) check("lat_data", do_a, i);
        end
        drain("drain_ramp");

        // 4x4 all-negative frame
`ifdef MAXPOOL2D_RELU_EN
        repeat (4) exp_q.push_back(0);
`else
        exp_q.push_back(-11); exp_q.push_back(-9); exp_q.push_back(-3); exp_q.push_back(-1);
`endif
        for (int i = 0; i < 16; i++) send(-16 + i);
        drain("drain_neg");

        // 5x5 frames back to back: last row and column dropped
        sel = 1;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(6); exp_q.push_back(8); exp_q.push_back(16); exp_q.push_back(18);
            for (int i = 0; i < 25; i++) send(i);
        end
        drain("drain_5x5");

        // Backpressure on the first output of a 4x4 ramp
        sel = 0;
        exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(13); exp_q.push_back(15);
        fork
            begin
                for (int i = 0; i < 16; i++) send(i);
            end
            begin
                for (int t = 0; t < 200 && vo_a !== 1'b1; t++) begin
                    @(posedge clk); #1;
                end
                rdy = 1'b0;
                check("bp_seen", vo_a, 1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", do_a, 5);
                    check("bp_valid", vo_a, 1);
                    check("bp_ready", ro_a, 0);
                end
                @(posedge clk); #1 rdy = 1'b1;
            end
        join
        drain("drain_bp");

        // Three 158x118 random frames with random valid/ready
        sel = 2;
        rand_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < big_w * big_h; i++) frame[i] = $signed($urandom());
            push_model(big_w, big_h);
            for (int i = 0; i < big_w * big_h; i++) send(frame[i]);
        end
        rand_mode = 1'b0;
        @(posedge clk); #1 rdy = 1'b1;
        drain("drain_rand");

        // Reset mid-frame, then a clean ramp
        sel = 0;
        exp_q.push_back(5);
        for (int i = 0; i < 6; i++) send(i);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("mid_rst_valid", vo_a, 0);
        check("mid_rst_data", do_a, 0);
        check("mid_rst_q", exp_q.size(), 0);
        exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(13); exp_q.push_back(15);
        for (int i = 0; i < 16; i++) send(i);
        drain("drain_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
